// File: rtl/i2s_receive_24.sv
// I2S receiver: oversamples SCK/WS/SD in the clk domain, deserialises Philips-framed
// DATA_W-bit words and queues them with a channel tag into a small valid/ready FIFO.
module i2s_receive_24 #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  input  logic              enable_i,
  input  logic              clear_err_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_right_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              overrun_o,
  output logic              short_frame_o,
  output logic [2:0]        debug_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DELAY = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pin synchronisers plus one delay stage on SCK and WS for edge detection.
  logic sck_s1_q, sck_s2_q, sck_dly_q;
  logic ws_s1_q, ws_s2_q, ws_dly_q;
  logic sd_s1_q, sd_s2_q;

  state_t            state_q, state_d;
  logic              chan_q, chan_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push_q, push_d;
  logic              overrun_q, overrun_d;
  logic              short_q, short_d;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [DATA_W:0] mem_q [FIFO_DEPTH];

  logic sck_fall, ws_edge, short_evt;
  logic fifo_valid, fifo_full, pop, push_ok, overrun_evt;
  logic [DATA_W:0] head;

  assign sck_fall = sck_dly_q & ~sck_s2_q;
  assign ws_edge  = ws_dly_q != ws_s2_q;

  // NOTE: every state element updates with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_dly_q <= 1'b0;
      ws_s1_q   <= 1'b0;
      ws_s2_q   <= 1'b0;
      ws_dly_q  <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      chan_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      overrun_q <= 1'b0;
      short_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      sck_s1_q  <= sck_i;
      sck_s2_q  <= sck_s1_q;
      sck_dly_q <= sck_s2_q;
      ws_s1_q   <= ws_i;
      ws_s2_q   <= ws_s1_q;
      ws_dly_q  <= ws_s2_q;
      sd_s1_q   <= sd_i;
      sd_s2_q   <= sd_s1_q;
      state_q   <= state_d;
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      overrun_q <= overrun_d;
      short_q   <= short_d;
      count_q   <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    short_evt = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (ws_edge) begin
            state_d = ST_DELAY;
            chan_d  = ws_s2_q;
            cnt_d   = '0;
          end
        end
        ST_DELAY, ST_SHIFT, ST_DONE: begin
          // A WS edge restarts the slot and swallows any coincident SCK fall.
          if (ws_edge) begin
            state_d   = ST_DELAY;
            chan_d    = ws_s2_q;
            cnt_d     = '0;
            short_evt = (state_q != ST_DONE);
          end else if (sck_fall) begin
            if (state_q == ST_DELAY) begin
              state_d = ST_SHIFT;
              cnt_d   = '0;
            end else if (state_q == ST_SHIFT) begin
              shift_d = {shift_q[DATA_W-2:0], sd_s2_q};
              cnt_d   = cnt_q + 1'b1;
              if (cnt_q == LAST_BIT) begin
                push_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fifo_valid  = count_q != '0;
  assign fifo_full   = count_q == DEPTH_CNT;
  assign pop         = fifo_valid & sample_ready_i;
  assign push_ok     = push_q & (~fifo_full | pop);
  assign overrun_evt = push_q & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error flags: a same-cycle event beats the clear.
  assign overrun_d = (overrun_q & ~clear_err_i) | overrun_evt;
  assign short_d   = (short_q & ~clear_err_i) | short_evt;

  // NOTE: storage is not reset; the outputs below are masked by valid instead.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {chan_q, shift_q};
  end

  assign head           = mem_q[rd_ptr_q];
  assign sample_valid_o = fifo_valid;
  assign sample_o       = fifo_valid ? head[DATA_W-1:0] : '0;
  assign sample_right_o = fifo_valid & head[DATA_W];
  assign overrun_o      = overrun_q;
  assign short_frame_o  = short_q;
  assign debug_state_o  = state_q;

endmodule

// File: tb/tb_i2s_receive_24.sv
// Directed bench for i2s_receive_24: drives a transmitter-timed I2S bit stream and
// checks captured words, flags, backpressure, resets and same-cycle corner cases.
module tb_i2s_receive_24;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sck_i = 1'b0;
  logic        ws_i  = 1'b1;
  logic        sd_i  = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_err_i = 1'b0;
  logic        sample_ready_i = 1'b1;
  logic [23:0] sample_o;
  logic        sample_right_o;
  logic        sample_valid_o;
  logic        overrun_o;
  logic        short_frame_o;
  logic [2:0]  debug_state_o;

  int tests = 0;
  int fails = 0;
  logic [24:0] cap_q [$];

  i2s_receive_24 #(.FIFO_DEPTH(2), .DATA_W(24)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .enable_i(enable_i), .clear_err_i(clear_err_i),
    .sample_o(sample_o), .sample_right_o(sample_right_o),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .overrun_o(overrun_o), .short_frame_o(short_frame_o),
    .debug_state_o(debug_state_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every accepted handshake as {right, sample}.
  always @(posedge clk_i) begin
    if (sample_valid_o && sample_ready_i) cap_q.push_back({sample_right_o, sample_o});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One SCK period (8 clk): rise, update WS/SD, fall (receiver samples), optional ready pulse.
  task automatic send_bit(input logic ws, input logic b, input logic pulse);
    @(negedge clk_i) sck_i = 1'b1;
    @(negedge clk_i) begin ws_i = ws; sd_i = b; end
    repeat (3) @(negedge clk_i);
    sck_i = 1'b0;
    if (pulse) begin
      repeat (3) @(negedge clk_i);
      sample_ready_i = 1'b1;
      @(negedge clk_i) sample_ready_i = 1'b0;
    end else begin
      repeat (3) @(negedge clk_i);
    end
  endtask

  // 32-bit slot: delay bit 0, 24 data bits MSB first, 7 zero pad; bits first..last sent.
  task automatic send_slot(input logic ws, input logic [23:0] data, input int first,
                           input int last, input int en_at, input int pulse_at);
    logic [23:0] sh;
    logic b;
    sh = data;
    for (int i = 0; i <= last; i++) begin
      b = 1'b0;
      if (i >= 1 && i <= 24) begin
        b  = sh[23];
        sh = sh << 1;
      end
      if (i >= first) begin
        if (i == en_at) enable_i = 1'b1;
        send_bit(ws, b, i == pulse_at);
      end
    end
  endtask

  task automatic slot(input logic ws, input logic [23:0] data);
    send_slot(ws, data, 0, 31, -1, -1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 2000 && cap_q.size() < n; i++) @(negedge clk_i);
    check("word_count", 32'(cap_q.size()), 32'(n));
  endtask

  task automatic pulse_clear();
    @(negedge clk_i) clear_err_i = 1'b1;
    @(negedge clk_i) clear_err_i = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_sample", 32'(sample_o), 32'h0);
    check("rst_valid", 32'(sample_valid_o), 32'h0);
    check("rst_right", 32'(sample_right_o), 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);
    check("rst_short", 32'(short_frame_o), 32'h0);
    check("rst_state", 32'(debug_state_o), 32'd0);

    // Stereo frame
    repeat (4) @(negedge clk_i);
    enable_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("sync_state", 32'(debug_state_o), 32'd1);
    cap_q.delete();
    slot(1'b0, 24'h7FFFFF);
    slot(1'b1, 24'h800001);
    wait_words(2);
    check("stereo_w0", 32'(cap_q[0]), {7'd0, 1'b0, 24'h7FFFFF});
    check("stereo_w1", 32'(cap_q[1]), {7'd0, 1'b1, 24'h800001});
    check("stereo_overrun", 32'(overrun_o), 32'h0);
    check("stereo_short", 32'(short_frame_o), 32'h0);
    check("done_state", 32'(debug_state_o), 32'd4);

    // Backpressure and overrun
    sample_ready_i = 1'b0;
    cap_q.delete();
    slot(1'b0, 24'h111111);
    check("bp_valid", 32'(sample_valid_o), 32'h1);
    check("bp_head1", 32'(sample_o), 32'h111111);
    slot(1'b1, 24'h222222);
    check("bp_head_stable", 32'(sample_o), 32'h111111);
    check("bp_no_overrun", 32'(overrun_o), 32'h0);
    slot(1'b0, 24'h333333);
    check("bp_overrun", 32'(overrun_o), 32'h1);
    check("bp_head_kept", 32'(sample_o), 32'h111111);
    check("bp_right_kept", 32'(sample_right_o), 32'h0);
    sample_ready_i = 1'b1;
    wait_words(2);
    check("bp_drain0", 32'(cap_q[0]), {7'd0, 1'b0, 24'h111111});
    check("bp_drain1", 32'(cap_q[1]), {7'd0, 1'b1, 24'h222222});
    repeat (4) @(negedge clk_i);
    check("bp_empty", 32'(sample_valid_o), 32'h0);
    check("bp_count_final", 32'(cap_q.size()), 32'd2);
    pulse_clear();
    check("bp_clear", 32'(overrun_o), 32'h0);

    // Short frame: WS toggles after 10 data bits
    cap_q.delete();
    send_slot(1'b1, 24'hFFFFFF, 0, 10, -1, -1);
    slot(1'b0, 24'h123456);
    wait_words(1);
    check("short_word", 32'(cap_q[0]), {7'd0, 1'b0, 24'h123456});
    check("short_flag", 32'(short_frame_o), 32'h1);
    check("short_no_overrun", 32'(overrun_o), 32'h0);
    pulse_clear();
    check("short_clear", 32'(short_frame_o), 32'h0);

    // Enable asserted mid-frame at bit 12 of a left word
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("disabled_state", 32'(debug_state_o), 32'd0);
    cap_q.delete();
    slot(1'b1, 24'h000000);
    send_slot(1'b0, 24'h0F1E2D, 0, 31, 12, -1);
    slot(1'b1, 24'hABCDEF);
    wait_words(1);
    repeat (8) @(negedge clk_i);
    check("midEn_count", 32'(cap_q.size()), 32'd1);
    check("midEn_word", 32'(cap_q[0]), {7'd0, 1'b1, 24'hABCDEF});
    check("midEn_short", 32'(short_frame_o), 32'h0);

    // SCK fall coincident with WS edge counts as nothing
    cap_q.delete();
    @(negedge clk_i) sck_i = 1'b1;
    @(negedge clk_i) sd_i = 1'b1;
    repeat (3) @(negedge clk_i);
    sck_i = 1'b0;
    ws_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    slot(1'b0, 24'h000001);
    wait_words(1);
    check("align_word", 32'(cap_q[0]), {7'd0, 1'b0, 24'h000001});
    check("align_short", 32'(short_frame_o), 32'h0);

    // Push and pop together on a full FIFO
    sample_ready_i = 1'b0;
    cap_q.delete();
    slot(1'b1, 24'hAAAAAA);
    slot(1'b0, 24'h555555);
    check("full_head", 32'(sample_o), 32'hAAAAAA);
    send_slot(1'b1, 24'h0F0F0F, 0, 31, -1, 24);
    check("pp_no_overrun", 32'(overrun_o), 32'h0);
    check("pp_popped", 32'(cap_q[0]), {7'd0, 1'b1, 24'hAAAAAA});
    check("pp_head", 32'(sample_o), 32'h555555);
    sample_ready_i = 1'b1;
    wait_words(3);
    check("pp_w1", 32'(cap_q[1]), {7'd0, 1'b0, 24'h555555});
    check("pp_w2", 32'(cap_q[2]), {7'd0, 1'b1, 24'h0F0F0F});

    // Reset at bit 20 of a left word, enable held
    sample_ready_i = 1'b0;
    slot(1'b0, 24'h777777);
    slot(1'b1, 24'h7A7A7A);
    check("pre_rst_valid", 32'(sample_valid_o), 32'h1);
    send_slot(1'b0, 24'h2468AC, 0, 20, -1, -1);
    @(negedge clk_i) rst_i = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
    check("mid_rst_valid", 32'(sample_valid_o), 32'h0);
    check("mid_rst_sample", 32'(sample_o), 32'h0);
    check("mid_rst_right", 32'(sample_right_o), 32'h0);
    check("mid_rst_state", 32'(debug_state_o), 32'd0);
    @(negedge clk_i);
    check("post_rst_sync", 32'(debug_state_o), 32'd1);
    send_slot(1'b0, 24'h2468AC, 21, 31, -1, -1);
    cap_q.delete();
    sample_ready_i = 1'b1;
    slot(1'b1, 24'h13579B);
    wait_words(1);
    repeat (8) @(negedge clk_i);
    check("rst_recover_count", 32'(cap_q.size()), 32'd1);
    check("rst_recover_word", 32'(cap_q[0]), {7'd0, 1'b1, 24'h13579B});
    check("rst_recover_short", 32'(short_frame_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
